// File: rtl/acquisition_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acquisition_sequencer_pkg
// Description : Shared definitions for the acquisition sequencer: register
//               map, command bit indices, sequencer state encoding and a
//               small helper for the effective pretrigger computation.
// Revision    : 1.0 - initial release
// ============================================================================
package acquisition_sequencer_pkg;

    // Working counter width (num_samples / pretrigger / sample counters)
    localparam int c_CNT_W = 16;

    // Register map
    localparam int c_ADDR_REQUESTS    = 5;
    localparam int c_ADDR_NUM_SAMPLES = 6;
    localparam int c_ADDR_PRETRIGGER  = 7;

    // Command register bit indices
    localparam int c_CMD_W        = 4;
    localparam int c_CMD_START    = 0;
    localparam int c_CMD_STOP     = 1;
    localparam int c_CMD_READ_CH1 = 2;
    localparam int c_CMD_READ_CH2 = 3;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_FULL      = 3'd4,
        ST_READ1     = 3'd5,
        ST_READ2     = 3'd6
    } acq_state_t;

    // Pretrigger can never exceed the capture length
    function automatic logic [c_CNT_W-1:0] eff_pretrigger(
        input logic [c_CNT_W-1:0] pretrigger,
        input logic [c_CNT_W-1:0] num_samples
    );
        return (pretrigger < num_samples) ? pretrigger : num_samples;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fully_associative_register.sv
`default_nettype none
// ============================================================================
// Module      : fully_associative_register
// Description : One configuration register on the shared register bus.
//               Captures i_data when i_wr is high and i_addr matches ADDR;
//               the new value is visible on o_value after that edge.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_addr/i_data - register bus address / data
//               i_wr          - register bus write strobe
//               o_value       - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module fully_associative_register #(
    parameter int                     ADDR_WIDTH  = 8,
    parameter int                     DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0]  ADDR        = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_wr,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [DATA_WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= RESET_VALUE;
        end else if (i_wr && (i_addr == ADDR)) begin
            r_value <= i_data;
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/acquisition_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acquisition_sequencer
// Description : Sequences one capture-and-readout cycle for two channel
//               blocks: decodes register-bus commands, holds num_samples /
//               pretrigger, counts pre- and post-trigger samples around the
//               trigger, then requests CH1 and/or CH2 readout one at a time.
// Ports       : clk, rst                      - clock, sync active-high reset
//               register_addr/data/rdy        - register bus write port
//               adc_rdy                       - sample strobe (CH1 timebase)
//               trigger_i                     - one-cycle trigger pulse
//               we                            - RAM write enable, both channels
//               num_samples                   - num_samples register value
//               rqst_data_ch1/ch2             - one-cycle readout requests
//               tx_eof_chX / tx_ack_chX       - per-channel Tx completion
//               busy, buffer_full, triggered  - status
// Revision    : 1.0 - initial release
// ============================================================================
module acquisition_sequencer
    import acquisition_sequencer_pkg::*;
#(
    parameter int REG_ADDR_WIDTH      = 8,
    parameter int REG_DATA_WIDTH      = 16,   // must be >= 16
    parameter int ADDR_REQUESTS       = c_ADDR_REQUESTS,
    parameter int ADDR_NUM_SAMPLES    = c_ADDR_NUM_SAMPLES,
    parameter int ADDR_PRETRIGGER     = c_ADDR_PRETRIGGER,
    parameter int DEFAULT_NUM_SAMPLES = 1024,
    parameter int DEFAULT_PRETRIGGER  = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] register_addr,
    input  logic [REG_DATA_WIDTH-1:0] register_data,
    input  logic                      register_rdy,
    input  logic                      adc_rdy,
    input  logic                      trigger_i,
    output logic                      we,
    output logic [c_CNT_W-1:0]        num_samples,
    output logic                      rqst_data_ch1,
    output logic                      rqst_data_ch2,
    input  logic                      tx_eof_ch1,
    input  logic                      tx_ack_ch1,
    input  logic                      tx_eof_ch2,
    input  logic                      tx_ack_ch2,
    output logic                      busy,
    output logic                      buffer_full,
    output logic                      triggered
);

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] w_num_samples;
    logic [c_CNT_W-1:0] w_pretrigger;

    fully_associative_register #(
        .ADDR_WIDTH  (REG_ADDR_WIDTH),
        .DATA_WIDTH  (c_CNT_W),
        .ADDR        (REG_ADDR_WIDTH'(ADDR_NUM_SAMPLES)),
        .RESET_VALUE (c_CNT_W'(DEFAULT_NUM_SAMPLES))
    ) u_num_samples_reg (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (register_addr),
        .i_data  (register_data[c_CNT_W-1:0]),
        .i_wr    (register_rdy),
        .o_value (w_num_samples)
    );

    fully_associative_register #(
        .ADDR_WIDTH  (REG_ADDR_WIDTH),
        .DATA_WIDTH  (c_CNT_W),
        .ADDR        (REG_ADDR_WIDTH'(ADDR_PRETRIGGER)),
        .RESET_VALUE (c_CNT_W'(DEFAULT_PRETRIGGER))
    ) u_pretrigger_reg (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (register_addr),
        .i_data  (register_data[c_CNT_W-1:0]),
        .i_wr    (register_rdy),
        .o_value (w_pretrigger)
    );

    // ------------------------------------------------------------------
    // Command decode: a write to the request address becomes a set of
    // one-cycle pulses that the sequencer acts on in the following cycle.
    // ------------------------------------------------------------------
    logic [c_CMD_W-1:0] r_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (register_rdy && (register_addr == REG_ADDR_WIDTH'(ADDR_REQUESTS))) begin
            r_cmd <= register_data[c_CMD_W-1:0];
        end else begin
            r_cmd <= '0;
        end
    end

    logic w_cmd_start;
    logic w_cmd_stop;
    logic w_cmd_rd1;
    logic w_cmd_rd2;

    // STOP overrides a START carried in the same write
    assign w_cmd_stop  = r_cmd[c_CMD_STOP];
    assign w_cmd_start = r_cmd[c_CMD_START] & ~w_cmd_stop;
    assign w_cmd_rd1   = r_cmd[c_CMD_READ_CH1];
    assign w_cmd_rd2   = r_cmd[c_CMD_READ_CH2];

    // ------------------------------------------------------------------
    // Sequencer state and working counters
    // ------------------------------------------------------------------
    acq_state_t         r_state;
    acq_state_t         w_state_next;
    logic [c_CNT_W-1:0] r_pre_cnt;
    logic [c_CNT_W-1:0] r_post_cnt;
    logic [c_CNT_W-1:0] r_pre_target;
    logic [c_CNT_W-1:0] r_post_target;
    logic               r_read_ch2;
    logic               r_triggered;
    logic               r_buffer_full;
    logic               r_rqst_ch1;
    logic               r_rqst_ch2;

    logic               w_capture_start;
    logic               w_trig_accept;
    logic               w_capture_done;
    logic               w_abort;
    logic               w_read1_enter;
    logic               w_read2_enter;
    logic               w_pre_hit;
    logic               w_post_hit;

    // A phase ends either because its target was already met (zero-length
    // phase) or because this cycle's sample brings the count to the target.
    assign w_pre_hit  = (r_pre_cnt == r_pre_target) ||
                        (adc_rdy && ((r_pre_cnt + c_CNT_W'(1)) == r_pre_target));
    assign w_post_hit = (r_post_cnt == r_post_target) ||
                        (adc_rdy && ((r_post_cnt + c_CNT_W'(1)) == r_post_target));

    always_comb begin
        w_state_next    = r_state;
        w_capture_start = 1'b0;
        w_trig_accept   = 1'b0;
        w_capture_done  = 1'b0;
        w_abort         = 1'b0;
        w_read1_enter   = 1'b0;
        w_read2_enter   = 1'b0;

        case (r_state)
            ST_IDLE, ST_FULL: begin
                if (w_cmd_start && (w_num_samples != '0)) begin
                    w_state_next    = ST_PRE;
                    w_capture_start = 1'b1;
                end else if ((r_state == ST_FULL) && w_cmd_rd1) begin
                    w_state_next  = ST_READ1;
                    w_read1_enter = 1'b1;
                end else if ((r_state == ST_FULL) && w_cmd_rd2) begin
                    w_state_next  = ST_READ2;
                    w_read2_enter = 1'b1;
                end
            end
            ST_PRE: begin
                if (w_cmd_stop) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else if (w_pre_hit) begin
                    w_state_next = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (w_cmd_stop) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else if (trigger_i) begin
                    w_state_next  = ST_POST;
                    w_trig_accept = 1'b1;
                end
            end
            ST_POST: begin
                if (w_cmd_stop) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else if (w_post_hit) begin
                    w_state_next   = ST_FULL;
                    w_capture_done = 1'b1;
                end
            end
            ST_READ1: begin
                if (tx_eof_ch1 && tx_ack_ch1) begin
                    if (r_read_ch2) begin
                        w_state_next  = ST_READ2;
                        w_read2_enter = 1'b1;
                    end else begin
                        w_state_next = ST_FULL;
                    end
                end
            end
            ST_READ2: begin
                if (tx_eof_ch2 && tx_ack_ch2) begin
                    w_state_next = ST_FULL;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_pre_target  <= '0;
            r_post_target <= '0;
            r_read_ch2    <= 1'b0;
            r_triggered   <= 1'b0;
            r_buffer_full <= 1'b0;
            r_rqst_ch1    <= 1'b0;
            r_rqst_ch2    <= 1'b0;
        end else begin
            // Requests are registered so they appear on the first cycle in
            // the read state and last exactly one cycle.
            r_rqst_ch1 <= w_read1_enter;
            r_rqst_ch2 <= w_read2_enter;

            if (w_read1_enter) begin
                r_read_ch2 <= w_cmd_rd2;
            end

            if (w_capture_start) begin
                // Snapshot configuration so later writes leave this capture alone
                r_pre_cnt     <= '0;
                r_post_cnt    <= '0;
                r_pre_target  <= eff_pretrigger(w_pretrigger, w_num_samples);
                r_post_target <= w_num_samples - eff_pretrigger(w_pretrigger, w_num_samples);
                r_triggered   <= 1'b0;
                r_buffer_full <= 1'b0;
            end else begin
                if ((r_state == ST_PRE) && adc_rdy && (r_pre_cnt < r_pre_target)) begin
                    r_pre_cnt <= r_pre_cnt + c_CNT_W'(1);
                end
                if ((r_state == ST_POST) && adc_rdy && (r_post_cnt < r_post_target)) begin
                    r_post_cnt <= r_post_cnt + c_CNT_W'(1);
                end
                if (w_trig_accept) begin
                    r_triggered <= 1'b1;
                end
                if (w_capture_done) begin
                    r_buffer_full <= 1'b1;
                end else if (w_abort) begin
                    r_buffer_full <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign we            = (r_state == ST_PRE) || (r_state == ST_WAIT_TRIG) || (r_state == ST_POST);
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_FULL);
    assign num_samples   = w_num_samples;
    assign rqst_data_ch1 = r_rqst_ch1;
    assign rqst_data_ch2 = r_rqst_ch2;
    assign buffer_full   = r_buffer_full;
    assign triggered     = r_triggered;

endmodule
`default_nettype wire
